// File: rtl/dct2_4_tbuf_if.sv
// Row-side and column-side handshake bundle for the DCT-II transpose buffer.
// The row stage drives the master side and the buffer sits on the slave side.
interface dct2_4_tbuf_if #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0][IN_W-1:0]  ye;
   logic [1:0][IN_W-1:0]  yo;
   logic                  out_valid;
   logic                  out_ready;
   logic [3:0][OUT_W-1:0] col;
   logic [1:0]            col_idx;
   logic                  col_last;

   modport master (
      output in_valid, ye, yo, out_ready,
      input  in_ready, out_valid, col, col_idx, col_last
   );
   modport slave (
      input  in_valid, ye, yo, out_ready,
      output in_ready, out_valid, col, col_idx, col_last
   );
endinterface

// File: rtl/dct2_4_tbuf.sv
// 4-point DCT-II first-stage round/clip plus ping-pong 4x4 transpose buffer.
// Macro DCT2_TBUF_SAT_EN selects saturating clip; otherwise results wrap to OUT_W.
module dct2_4_tbuf_lane #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int SHIFT = 3
) (
   input  logic [IN_W-1:0]  i_c,
   output logic [OUT_W-1:0] o_r
);
   localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);

   logic signed [IN_W:0] w_sum;
   logic signed [IN_W:0] w_shr;

   // One extra bit of headroom so the rounding add can never overflow.
   assign w_sum = $signed({i_c[IN_W-1], i_c}) + $signed(RND);
   assign w_shr = w_sum >>> SHIFT;

`ifdef DCT2_TBUF_SAT_EN
   localparam logic signed [IN_W:0] SMAX = $signed({{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [IN_W:0] SMIN = ~SMAX;

   always_comb begin
      if (w_shr > SMAX)      o_r = SMAX[OUT_W-1:0];
      else if (w_shr < SMIN) o_r = SMIN[OUT_W-1:0];
      else                   o_r = w_shr[OUT_W-1:0];
   end
`else
   logic w_unused;
   assign w_unused = ^w_shr[IN_W:OUT_W];
   assign o_r      = w_shr[OUT_W-1:0];
`endif
endmodule

module dct2_4_tbuf #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int SHIFT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   dct2_4_tbuf_if.slave  s_if
);
   localparam int NUM_LANES = 4;

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bstate_e;

   bstate_e r_bstate     [2];
   bstate_e w_bstate_nxt [2];
   logic       r_wbank;
   logic       r_rbank;
   logic [1:0] r_row_ptr;
   logic [1:0] r_col_idx;

   logic [NUM_LANES-1:0][OUT_W-1:0] r_mem [2][4];

   logic                            w_in_ready;
   logic                            w_out_valid;
   logic                            w_wr;
   logic                            w_rd;
   logic [NUM_LANES-1:0][IN_W-1:0]  w_c;
   logic [NUM_LANES-1:0][OUT_W-1:0] w_r;
   logic [NUM_LANES-1:0][OUT_W-1:0] w_col;

   // Coefficient order within a row: ye0, yo0, ye1, yo1.
   assign w_c[0] = s_if.ye[0];
   assign w_c[1] = s_if.yo[0];
   assign w_c[2] = s_if.ye[1];
   assign w_c[3] = s_if.yo[1];

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      dct2_4_tbuf_lane #(
         .IN_W  (IN_W),
         .OUT_W (OUT_W),
         .SHIFT (SHIFT)
      ) u_lane (
         .i_c (w_c[gi]),
         .o_r (w_r[gi])
      );
      assign w_col[gi] = r_mem[r_rbank][gi][r_col_idx];
   end

   assign w_wr = s_if.in_valid  && w_in_ready;
   assign w_rd = w_out_valid    && s_if.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bstate[0] <= B_EMPTY;
         r_bstate[1] <= B_EMPTY;
      end else begin
         r_bstate[0] <= w_bstate_nxt[0];
         r_bstate[1] <= w_bstate_nxt[1];
      end
   end

   // A bank being written is never FULL and a bank being read always is,
   // so both updates below can never target the same bank in one cycle.
   always_comb begin
      w_bstate_nxt[0] = r_bstate[0];
      w_bstate_nxt[1] = r_bstate[1];
      if (w_wr)
         w_bstate_nxt[r_wbank] = (r_row_ptr == 2'd3) ? B_FULL : B_FILLING;
      if (w_rd && (r_col_idx == 2'd3))
         w_bstate_nxt[r_rbank] = B_EMPTY;
   end

   always_comb begin
      w_in_ready  = (r_bstate[r_wbank] != B_FULL);
      w_out_valid = (r_bstate[r_rbank] == B_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbank   <= 1'b0;
         r_rbank   <= 1'b0;
         r_row_ptr <= 2'd0;
         r_col_idx <= 2'd0;
      end else begin
         if (w_wr) begin
            r_row_ptr <= r_row_ptr + 2'd1;
            if (r_row_ptr == 2'd3) r_wbank <= ~r_wbank;
         end
         if (w_rd) begin
            r_col_idx <= r_col_idx + 2'd1;
            if (r_col_idx == 2'd3) r_rbank <= ~r_rbank;
         end
      end
   end

   // Storage needs no reset: nothing is read until a bank has been fully written.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wbank][r_row_ptr] <= w_r;
   end

   assign s_if.in_ready  = w_in_ready;
   assign s_if.out_valid = w_out_valid;
   assign s_if.col       = w_out_valid ? w_col : '0;
   assign s_if.col_idx   = r_col_idx;
   assign s_if.col_last  = w_out_valid && (r_col_idx == 2'd3);
endmodule
